// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared game constants and types for the VGA game pipeline.
//   - Sprite footprints for the cheese and for Jerry.
//   - Cheese controller state type, LFSR seed and default spawn bounds.
//   - cheese_wrap(): folds a raw LFSR field into [lo, hi].
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int CHEESE_WIDTH  = 32;
    localparam int CHEESE_HEIGHT = 24;
    localparam int JERRY_WIDTH   = 24;
    localparam int JERRY_HEIGHT  = 32;

    localparam logic [15:0] CHEESE_LFSR_SEED = 16'hACE1;

    localparam int CHEESE_X_MIN = 32;
    localparam int CHEESE_X_MAX = 700;
    localparam int CHEESE_Y_MIN = 100;
    localparam int CHEESE_Y_MAX = 450;

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        ACTIVE,
        WAIT
    } cheese_state_t;

    // The raw field is never more than twice the span, so a single
    // conditional subtraction is enough to land inside [lo, hi].
    function automatic logic [10:0] cheese_wrap(input logic [11:0] raw,
                                                input logic [11:0] lo,
                                                input logic [11:0] hi);
        logic [11:0] span;
        span = hi - lo;
        if (raw <= span)
            return 11'(lo + raw);
        return 11'(lo + raw - (span + 12'd1));
    endfunction

endpackage

// File: rtl/pos_if.sv
// -----------------------------------------------------------------------------
// pos_if
// Top-left sprite position bundle passed between pipeline stages.
//   x, y : 11-bit pixel coordinates
// Modports: in (consumer), out (producer).
// -----------------------------------------------------------------------------
interface pos_if;
    logic [10:0] x;
    logic [10:0] y;

    modport in  (input  x, input  y);
    modport out (output x, output y);
endinterface

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length).
// A non-zero seed guarantees the all-zero lock-up state is never reached.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset, loads SEED
//   state out current 16-bit register contents
// -----------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED;
        else
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end

endmodule

// File: rtl/cheese_ctl.sv
// -----------------------------------------------------------------------------
// cheese_ctl
// Game-logic controller for the cheese sprite. Spawns the cheese at a
// pseudo-random position, detects Jerry touching it, counts pickups and
// hides the cheese for RESPAWN_FRAMES frames before respawning it.
// All position / visibility / hit decisions happen only on the frame tick
// (rising edge of vblnk) so the sprite never moves mid-frame.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   vblnk     in   vertical blank; rising edge = frame tick
//   game_en   in   high while a game is running
//   pjerry    in   Jerry top-left position (pos_if.in)
//   pout      out  cheese top-left position to the draw stage (pos_if.out)
//   visible   out  cheese is drawn
//   collected out  one-cycle pulse on pickup
//   score     out  cheeses collected this game, saturating at 255
// -----------------------------------------------------------------------------
module cheese_ctl
    import game_pkg::*;
#(
    parameter int RESPAWN_FRAMES = 120,
    parameter int X_MIN          = CHEESE_X_MIN,
    parameter int X_MAX          = CHEESE_X_MAX,
    parameter int Y_MIN          = CHEESE_Y_MIN,
    parameter int Y_MAX          = CHEESE_Y_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       game_en,
    pos_if.in          pjerry,
    pos_if.out         pout,
    output logic       visible,
    output logic       collected,
    output logic [7:0] score
);

    localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);

    localparam logic [11:0] XLO = 12'(X_MIN);
    localparam logic [11:0] XHI = 12'(X_MAX);
    localparam logic [11:0] YLO = 12'(Y_MIN);
    localparam logic [11:0] YHI = 12'(Y_MAX);

    logic [15:0]      lfsr;
    logic             vblnk_q;
    logic             tick;
    logic             hit;
    logic [10:0]      spawn_x;
    logic [10:0]      spawn_y;

    cheese_state_t    state_q, state_d;
    logic [10:0]      pos_x_q, pos_y_q;
    logic [10:0]      pos_x_d, pos_y_d;
    logic             vis_d;
    logic             col_d;
    logic [7:0]       score_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    lfsr16 #(
        .SEED (CHEESE_LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign tick = vblnk & ~vblnk_q;

    assign spawn_x = cheese_wrap({2'b00, lfsr[15:6]}, XLO, XHI);
    assign spawn_y = cheese_wrap({3'b000, lfsr[8:0]}, YLO, YHI);

    // Strict inequalities: boxes that only share an edge do not overlap.
    // Widened to 12 bits so right/bottom edges near 2047 cannot wrap.
    always_comb begin
        logic [11:0] jx, jy, cx, cy;
        jx  = {1'b0, pjerry.x};
        jy  = {1'b0, pjerry.y};
        cx  = {1'b0, pos_x_q};
        cy  = {1'b0, pos_y_q};
        hit = (jx < cx + 12'(CHEESE_WIDTH))  && (cx < jx + 12'(JERRY_WIDTH)) &&
              (jy < cy + 12'(CHEESE_HEIGHT)) && (cy < jy + 12'(JERRY_HEIGHT));
    end

    assign pout.x = pos_x_q;
    assign pout.y = pos_y_q;

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vis_d   = visible;
        col_d   = 1'b0;
        score_d = score;
        cnt_d   = cnt_q;

        // Losing game_en overrides everything, including a coincident tick.
        if (!game_en) begin
            state_d = IDLE;
            vis_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    vis_d   = 1'b0;
                    score_d = 8'd0;
                    state_d = SPAWN;
                end
                SPAWN: begin
                    if (tick) begin
                        pos_x_d = spawn_x;
                        pos_y_d = spawn_y;
                        vis_d   = 1'b1;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (tick && hit) begin
                        col_d   = 1'b1;
                        score_d = (score == 8'hFF) ? score : score + 8'd1;
                        vis_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // cnt counts ticks already spent hidden; the tick that finds
                    // it at the last value is the RESPAWN_FRAMES-th one.
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            pos_x_d = spawn_x;
                            pos_y_d = spawn_y;
                            vis_d   = 1'b1;
                            state_d = ACTIVE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            visible   <= 1'b0;
            collected <= 1'b0;
            score     <= 8'd0;
            cnt_q     <= '0;
            vblnk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            visible   <= vis_d;
            collected <= col_d;
            score     <= score_d;
            cnt_q     <= cnt_d;
            vblnk_q   <= vblnk;
        end
    end

endmodule

// File: tb/tb_cheese_ctl.sv
// -----------------------------------------------------------------------------
// tb_cheese_ctl
// Self-checking bench for cheese_ctl with RESPAWN_FRAMES = 4. A frame-level
// reference model (hidden-frame countdown, modulo-based spawn placement)
// predicts every output after every clock edge; directed scenarios are
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_cheese_ctl;
    import game_pkg::*;

    localparam int RF    = 4;
    localparam int XMIN  = 32;
    localparam int XMAX  = 700;
    localparam int YMIN  = 100;
    localparam int YMAX  = 450;
    localparam int AWAY  = 1500;

    localparam int M_OFF    = 0;
    localparam int M_ARMED  = 1;
    localparam int M_SHOWN  = 2;
    localparam int M_HIDDEN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblnk;
    logic       game_en;
    logic       visible;
    logic       collected;
    logic [7:0] score;

    pos_if pj ();
    pos_if po ();

    cheese_ctl #(
        .RESPAWN_FRAMES (RF),
        .X_MIN          (XMIN),
        .X_MAX          (XMAX),
        .Y_MIN          (YMIN),
        .Y_MAX          (YMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vblnk),
        .game_en   (game_en),
        .pjerry    (pj),
        .pout      (po),
        .visible   (visible),
        .collected (collected),
        .score     (score)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_col_seen = 0;

    // reference model state
    int          m_mode;
    int          m_hide;
    logic [15:0] m_lfsr;
    logic        m_vq;
    bit          m_vis;
    bit          m_col;
    int          m_score;
    int          m_px;
    int          m_py;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit overlap(input int jx, input int jy, input int cx, input int cy);
        return (jx < cx + CHEESE_WIDTH) && (cx < jx + JERRY_WIDTH) &&
               (jy < cy + CHEESE_HEIGHT) && (cy < jy + JERRY_HEIGHT);
    endfunction

    task automatic place();
        int rx, ry;
        rx   = int'(m_lfsr[15:6]);
        ry   = int'(m_lfsr[8:0]);
        m_px = XMIN + rx % (XMAX - XMIN + 1);
        m_py = YMIN + ry % (YMAX - YMIN + 1);
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        bit tk;
        tk    = vblnk && !m_vq;
        m_col = 1'b0;
        if (rst) begin
            m_mode  = M_OFF;
            m_vis   = 1'b0;
            m_score = 0;
            m_px    = 0;
            m_py    = 0;
            m_hide  = 0;
            m_vq    = 1'b0;
            m_lfsr  = CHEESE_LFSR_SEED;
        end else begin
            if (!game_en) begin
                m_mode = M_OFF;
                m_vis  = 1'b0;
            end else begin
                case (m_mode)
                    M_OFF: begin
                        m_mode  = M_ARMED;
                        m_score = 0;
                    end
                    M_ARMED: begin
                        if (tk) begin
                            place();
                            m_vis  = 1'b1;
                            m_mode = M_SHOWN;
                        end
                    end
                    M_SHOWN: begin
                        if (tk && overlap(int'(pj.x), int'(pj.y), m_px, m_py)) begin
                            m_col = 1'b1;
                            if (m_score < 255) m_score++;
                            m_vis  = 1'b0;
                            m_hide = RF;
                            m_mode = M_HIDDEN;
                        end
                    end
                    default: begin
                        if (tk) begin
                            m_hide--;
                            if (m_hide == 0) begin
                                place();
                                m_vis  = 1'b1;
                                m_mode = M_SHOWN;
                            end
                        end
                    end
                endcase
            end
            m_vq   = vblnk;
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        if (collected === 1'b1) n_col_seen++;
        check_eq("vis",   32'(visible),   32'(m_vis));
        check_eq("col",   32'(collected), 32'(m_col));
        check_eq("score", 32'(score),     32'(m_score));
        check_eq("px",    32'(po.x),      32'(m_px));
        check_eq("py",    32'(po.y),      32'(m_py));
    endtask

    task automatic frame(input int hi, input int lo);
        vblnk = 1'b1;
        repeat (hi) cycle();
        vblnk = 1'b0;
        repeat (lo) cycle();
    endtask

    task automatic jerry_at(input int x, input int y);
        pj.x = 11'(x);
        pj.y = 11'(y);
    endtask

    initial begin
        int s0, c0, bx, by;
        rst     = 1'b1;
        vblnk   = 1'b0;
        game_en = 1'b0;
        jerry_at(AWAY, AWAY);
        repeat (3) cycle();
        check_eq("rst_visible", 32'(visible), 32'd0);
        check_eq("rst_score",   32'(score),   32'd0);
        check_eq("rst_pout_x",  32'(po.x),    32'd0);
        rst = 1'b0;

        // idle frames: nothing happens
        repeat (5) frame(2, 3);
        check_eq("idle_visible", 32'(visible),    32'd0);
        check_eq("idle_pulses",  32'(n_col_seen), 32'd0);
        check_eq("idle_pout_y",  32'(po.y),       32'd0);

        // first spawn
        game_en = 1'b1;
        cycle();
        frame(2, 3);
        check_eq("spawn_visible", 32'(visible), 32'd1);
        check_eq("spawn_x_range", 32'(po.x >= 11'(XMIN) && po.x <= 11'(XMAX)), 32'd1);
        check_eq("spawn_y_range", 32'(po.y >= 11'(YMIN) && po.y <= 11'(YMAX)), 32'd1);

        // pickup on exact overlap, respawn on 4th following tick
        jerry_at(m_px, m_py);
        c0 = n_col_seen;
        frame(2, 3);
        check_eq("pick_pulse", 32'(n_col_seen - c0), 32'd1);
        check_eq("pick_score", 32'(score),   32'd1);
        check_eq("pick_vis",   32'(visible), 32'd0);
        jerry_at(AWAY, AWAY);
        repeat (3) frame(2, 3);
        check_eq("wait_vis", 32'(visible), 32'd0);
        frame(2, 3);
        check_eq("respawn_vis", 32'(visible), 32'd1);

        // boundary: edges touching do not count
        jerry_at(m_px - JERRY_WIDTH, m_py);
        repeat (3) frame(2, 3);
        check_eq("edge_nopick", 32'(score), 32'd1);
        jerry_at(m_px - JERRY_WIDTH + 1, m_py);
        frame(2, 3);
        check_eq("edge_pick", 32'(score), 32'd2);
        jerry_at(AWAY, AWAY);
        repeat (RF) frame(2, 3);
        check_eq("respawn2_vis", 32'(visible), 32'd1);

        // overlap only between ticks
        bx = m_px;
        by = m_py;
        repeat (2) begin
            vblnk = 1'b1;
            cycle();
            vblnk = 1'b0;
            cycle();
            jerry_at(bx, by);
            repeat (3) cycle();
            jerry_at(AWAY, AWAY);
            cycle();
        end
        check_eq("between_score", 32'(score), 32'd2);
        check_eq("between_px",    32'(po.x),  32'(bx));

        // third pickup, then drop game_en in the hidden period
        jerry_at(m_px, m_py);
        frame(2, 3);
        jerry_at(AWAY, AWAY);
        frame(2, 3);
        check_eq("three_score", 32'(score), 32'd3);
        game_en = 1'b0;
        cycle();
        check_eq("drop_vis",   32'(visible), 32'd0);
        check_eq("drop_score", 32'(score),   32'd3);
        frame(2, 3);
        check_eq("drop_hold", 32'(score), 32'd3);
        game_en = 1'b1;
        cycle();
        check_eq("reen_score", 32'(score), 32'd0);
        frame(2, 3);
        check_eq("reen_vis", 32'(visible), 32'd1);

        // saturation: Jerry chases the cheese every frame
        repeat (1300) begin
            jerry_at(m_px, m_py);
            frame(1, 1);
        end
        check_eq("sat_score", 32'(score), 32'd255);

        // randomized phase
        repeat (400) begin
            int r, dx, dy;
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                dx = int'($urandom_range(0, CHEESE_WIDTH + JERRY_WIDTH - 2)) - (JERRY_WIDTH - 1);
                dy = int'($urandom_range(0, CHEESE_HEIGHT + JERRY_HEIGHT - 2)) - (JERRY_HEIGHT - 1);
                jerry_at(m_px + dx, m_py + dy);
            end else if (r < 90) begin
                jerry_at(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            end else begin
                jerry_at(AWAY, AWAY);
            end
            game_en = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            s0 = int'($urandom_range(1, 4));
            frame(s0, int'($urandom_range(1, 6)));
        end
        game_en = 1'b1;
        frame(2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
